// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared definitions for the I/D-cache memory arbiter:
//               default widths, FSM state encoding and grant-owner encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

  localparam int ADDR_W_DEFAULT = 28;
  localparam int DATA_W_DEFAULT = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } arb_state_e;

  // Owner of the most recent grant; also identifies the owner while in DONE.
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

endpackage : mem_arbiter_pkg
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter sharing one memory port between an
//               I-cache (fill only) and a D-cache (fill or write-back).
//               One transaction at a time: IDLE -> BUSY_x -> DONE -> IDLE.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  // I-cache
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  // D-cache
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  // Shared memory port
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  arb_state_e        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic d_req;
  logic pick_d;

  // Arbitration, transaction latching and completion sequencing.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    d_req        = d_read | d_write;
    pick_d       = 1'b0;

    case (state_q)
      IDLE: begin
        // On a tie the requester not granted last wins.
        if (i_read && d_req) pick_d = (last_grant_q == GRANT_I);
        else                 pick_d = d_req;

        if (pick_d) begin
          // Read and write together is treated as a write.
          mem_addr_d   = d_addr;
          mem_wdata_d  = d_wdata;
          mem_write_d  = d_write;
          mem_read_d   = ~d_write;
          last_grant_d = GRANT_D;
          state_d      = BUSY_D;
        end else if (i_read) begin
          mem_addr_d   = i_addr;
          mem_read_d   = 1'b1;
          mem_write_d  = 1'b0;
          last_grant_d = GRANT_I;
          state_d      = BUSY_I;
        end
      end

      BUSY_I, BUSY_D: begin
        if (mem_ready) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (mem_read_q) begin
            if (state_q == BUSY_I) i_rdata_d = mem_rdata;
            else                   d_rdata_d = mem_rdata;
          end
          state_d = DONE;
        end
      end

      DONE: begin
        // Requests are deliberately not sampled here so a request still
        // held during the completion cycle is not served twice.
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // DONE lasts one cycle; the owner is the most recent grant.
  assign i_ready   = (state_q == DONE) && (last_grant_q == GRANT_I);
  assign d_ready   = (state_q == DONE) && (last_grant_q == GRANT_D);
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule : mem_arbiter
`default_nettype wire
